i2c_eeprom_responder: RTL and testbench
=======================================

// Module: i2c_eeprom_responder
// PURPOSE
//  I2C target that emulates a 24xx-style 256-byte EEPROM. It is the responder end of the page-read/page-write
//  transactions issued by i2c_eeprom. Uses: node-config loopback on the bench and serving config from a second FPGA.
//  Sits beside the open-drain io_scl/io_sda tristate logic in a top level; memory preloadable from fabric.
// PARAMETERS
//  DEV_ADDR    7'h50  7-bit target address matched after START
//  PAGE_SIZE   8      write page size in bytes; write pointer wraps within page (power of 2)
//  SYNC_STAGES 2      flip-flop synchroniser depth on SCL/SDA inputs
// PORTS
//  clk         in   1  system clock (20 MHz); must be >= 20x SCL rate
//  reset       in   1  asynchronous, active-high reset
//  i_scl       in   1  SCL pin value
//  i_sda       in   1  SDA pin value
//  o_sda_t     out  1  1 = release SDA (Z), 0 = drive SDA low; SCL never driven (no clock stretching)
//  i_cfg_we    in   1  fabric preload write strobe
//  i_cfg_addr  in   8  fabric preload address
//  i_cfg_data  in   8  fabric preload data
//  o_busy      out  1  1 from matched address byte until STOP/abort
//  o_wr_done   out  1  1-cycle pulse at STOP ending a write with >=1 data byte
// BEHAVIOUR
//  Reset (async): o_sda_t=1, o_busy=0, o_wr_done=0, state IDLE, word pointer 0. Memory contents are not reset.
//  Input conditioning: SCL/SDA pass SYNC_STAGES flops; rise/fall edges detected on the synchronised values.
//  START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are recognised in every state.
//  Bits: sample SDA on SCL rise. o_sda_t changes only 1 clk after a synchronised SCL fall.
//  States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
//   IDLE: on START -> DEV_ADDR and clear the bit counter.
//   DEV_ADDR: shift 8 bits MSB first. Address match -> DEV_ACK with o_busy=1. Mismatch -> IDLE and never drive SDA.
//   DEV_ACK: drive ACK low for 1 SCL period. After the falling edge, R/W=0 -> WORD_ADDR and R/W=1 -> RD_DATA.
//    For RD_DATA, load the shift register from mem[ptr].
//   WORD_ADDR: 8 bits -> ptr. WORD_ACK acks, then -> WR_DATA.
//   WR_DATA: 8 bits. WR_ACK: drive ACK. The memory write happens at the ACK SCL rise: mem[ptr] <= byte.
//    ptr <= {ptr[7:log2(PAGE_SIZE)], ptr[low]+1}, i.e. the pointer wraps inside the page. Then -> WR_DATA.
//   RD_DATA: drive bits MSB first (o_sda_t = bit). After the 8th bit -> RD_ACK, release SDA, ptr <= ptr+1 (wraps 255->0).
//   RD_ACK: sample the controller ACK. ACK=0 -> load mem[ptr] and go to RD_DATA. NACK=1 -> WAIT_STOP with SDA released.
//  Repeated START in any state -> DEV_ADDR with ptr kept (current-address / random read).
//  STOP in any state -> IDLE with o_sda_t=1 and o_busy=0. o_wr_done pulses if >=1 byte was written since the last START.
//  START/STOP seen mid-byte discards the partial byte and performs no memory write.
//  Fabric preload is honoured only when o_busy=0 and ignored otherwise. Same-cycle access: the I2C write wins.
//  Read data latency: the byte is loaded at least 1 clk before the first SCL fall in which it is driven.
//  Memory: 256x8 synchronous array with 1 write port, muxed between I2C and preload.
// STRUCTURE
//  Shared include i2c_defs.vh: `define state codes (4-bit), I2C_ACK=1'b0, I2C_NACK=1'b1.
//   It is shared with i2c_eeprom.
//  Sub-module i2c_line_sync: synchroniser plus registered scl_rise, scl_fall, start_det, stop_det outputs.
//  FSM, shift register, bit counter, pointer and memory live in this module.
// TESTING (bench: i2c_eeprom master, prescale 16'h0320, pull-up model on both lines)
//  1 Preload mem[0..7]=01..08, then master page read at 0x00 -> o_page_b0..b7 = 01..08 and o_done pulses.
//  2 Write ptr 0x06, data AA BB CC -> mem[06]=AA, mem[07]=BB, mem[00]=CC (page wrap); o_wr_done=1 for 1 clk.
//  3 Address 0x51 -> NACK on the 9th clock, SDA never driven, o_busy stays 0, memory unchanged.
//  4 Read at ptr 0xFF for 2 bytes -> mem[FF] then mem[00]. Master NACK -> SDA released until STOP.
//  5 Assert reset during RD_DATA with SDA driven low -> o_sda_t=1 in the same cycle.
//    After release, the next START+0x50 is acked.
//  6 Preload i_cfg_we while o_busy=1 -> ignored. The same write after STOP -> applied.

Source files
------------

// File: rtl/i2c_eeprom_responder_pkg.sv
// Shared definitions for the I2C EEPROM responder.
// Contents: the responder FSM state type, the ACK/NACK bit levels and a
// helper that advances the write pointer while keeping it inside a page.
package i2c_eeprom_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_WORD_ADDR = 4'd3,
        ST_WORD_ACK  = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // The upper pointer bits select the page and are never touched.
    // Only the in-page bits (mask) count up and wrap.
    function automatic logic [7:0] page_inc(input logic [7:0] ptr, input logic [7:0] mask);
        return (ptr & ~mask) | ((ptr + 8'd1) & mask);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for the I2C responder.
// Purpose: synchronise the SCL/SDA pins into the clk domain and produce
// single-cycle event pulses.
// Ports:
//   clk, reset         system clock, async active-high reset
//   scl, sda           raw pin values
//   scl_rise/scl_fall  one-cycle pulses on synchronised SCL edges
//   start_det/stop_det one-cycle pulses on START (SDA fall, SCL high) and STOP (SDA rise, SCL high)
//   sda_bit            synchronised SDA, time-aligned with the pulses above
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic scl_s;
    logic sda_s;
    logic scl_d;
    logic sda_d;

    assign scl_s = scl_sr[SYNC_STAGES-1];
    assign sda_s = sda_sr[SYNC_STAGES-1];

    // Reset to the idle bus level (both lines high) so releasing reset
    // never looks like a START or STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sr    <= '1;
            sda_sr    <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= 1'b1;
        end else begin
            scl_sr    <= (scl_sr << 1) | SYNC_STAGES'(scl);
            sda_sr    <= (sda_sr << 1) | SYNC_STAGES'(sda);
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            scl_rise  <= scl_s & ~scl_d;
            scl_fall  <= ~scl_s & scl_d;
            // SCL must be high on both samples so an SDA change right at an
            // SCL edge is never mistaken for a bus condition.
            start_det <= scl_s & scl_d & sda_d & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda_d & sda_s;
            sda_bit   <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 24xx-style 256-byte EEPROM.
// Purpose: answers page reads/writes from an I2C controller; memory can be
// preloaded from fabric while the bus is idle.
// Ports:
//   clk                 system clock (>= 20x SCL rate)
//   reset               async active-high reset (memory contents kept)
//   i_scl, i_sda        pin values
//   o_sda_t             1 = release SDA, 0 = pull SDA low (SCL never driven)
//   i_cfg_we/addr/data  fabric preload port, ignored while o_busy=1
//   o_busy              high from a matched address byte until STOP/abort
//   o_wr_done           one-cycle pulse at a STOP that ends a write of >= 1 byte
module i2c_eeprom_responder
    import i2c_eeprom_responder_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned PAGE_SIZE   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_t,
    input  logic       i_cfg_we,
    input  logic [7:0] i_cfg_addr,
    input  logic [7:0] i_cfg_data,
    output logic       o_busy,
    output logic       o_wr_done
);

    localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_bit;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw_bit;
    logic       ack_on;
    logic       wrote;
    logic [7:0] byte_in;

    logic [7:0] mem [0:255];
    logic [7:0] rd_data;
    logic       i2c_we;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (i_scl),
        .sda       (i_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    // Byte as it will look once the bit sampled on this SCL rise is shifted in.
    assign byte_in = {shreg[6:0], sda_bit};

    // Single write port: the I2C write happens at the ACK SCL rise and beats
    // a simultaneous preload; preload is only honoured while idle.
    always_comb begin
        i2c_we    = (state == ST_WR_ACK) && ack_on && scl_rise;
        mem_we    = i2c_we || (i_cfg_we && !o_busy);
        mem_addr  = i2c_we ? ptr   : i_cfg_addr;
        mem_wdata = i2c_we ? shreg : i_cfg_data;
    end

    // Memory has no reset. rd_data continuously follows mem[ptr] one clock
    // late, so a read byte is ready long before the FSM needs it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_data <= mem[ptr];
    end

    // Bus FSM. Bits are sampled on scl_rise; SDA is only changed on scl_fall.
    // Ack states use ack_on: first fall starts driving ACK, second fall ends it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            ptr       <= 8'd0;
            rw_bit    <= 1'b0;
            ack_on    <= 1'b0;
            wrote     <= 1'b0;
            o_sda_t   <= 1'b1;
            o_busy    <= 1'b0;
            o_wr_done <= 1'b0;
        end else begin
            o_wr_done <= 1'b0;
            if (stop_det) begin
                state     <= ST_IDLE;
                o_sda_t   <= 1'b1;
                o_busy    <= 1'b0;
                ack_on    <= 1'b0;
                o_wr_done <= wrote;
                wrote     <= 1'b0;
            end else if (start_det) begin
                // Repeated START keeps ptr for current-address / random reads.
                state   <= ST_DEV_ADDR;
                bit_cnt <= 3'd0;
                o_sda_t <= 1'b1;
                ack_on  <= 1'b0;
                wrote   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end

                    ST_DEV_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state  <= ST_DEV_ACK;
                                    o_busy <= 1'b1;
                                    rw_bit <= byte_in[0];
                                end else begin
                                    state  <= ST_IDLE;
                                    o_busy <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                o_sda_t <= I2C_ACK;
                                ack_on  <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (rw_bit) begin
                                    state   <= ST_RD_DATA;
                                    o_sda_t <= shreg[7];
                                    shreg   <= {shreg[6:0], 1'b0};
                                end else begin
                                    state   <= ST_WORD_ADDR;
                                    o_sda_t <= 1'b1;
                                end
                            end
                        end else if (scl_rise && ack_on && rw_bit) begin
                            // Preload the first read byte during the ACK clock.
                            shreg <= rd_data;
                        end
                    end

                    ST_WORD_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr   <= byte_in;
                                state <= ST_WORD_ACK;
                            end
                        end
                    end

                    ST_WORD_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                o_sda_t <= I2C_ACK;
                                ack_on  <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= 3'd0;
                                o_sda_t <= 1'b1;
                                state   <= ST_WR_DATA;
                            end
                        end else if (scl_rise && ack_on && (state == ST_WR_ACK)) begin
                            ptr   <= page_inc(ptr, PAGE_MASK);
                            wrote <= 1'b1;
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_WR_ACK;
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            o_sda_t <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_RD_ACK;
                                ptr   <= ptr + 8'd1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_fall) begin
                            o_sda_t <= 1'b1;
                        end else if (scl_rise) begin
                            if (sda_bit == I2C_NACK) begin
                                state <= ST_WAIT_STOP;
                            end else begin
                                shreg   <= rd_data;
                                bit_cnt <= 3'd0;
                                state   <= ST_RD_DATA;
                            end
                        end
                    end

                    ST_WAIT_STOP: begin
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Testbench for i2c_eeprom_responder.
// A bit-banged I2C controller with a wired-AND pull-up model drives the
// responder through directed transactions; each test task checks its own results.
module tb_i2c_eeprom_responder;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_line;
    logic       sda_line;
    logic       o_sda_t;
    logic       i_cfg_we = 1'b0;
    logic [7:0] i_cfg_addr = 8'd0;
    logic [7:0] i_cfg_data = 8'd0;
    logic       o_busy;
    logic       o_wr_done;

    int total = 0;
    int bad = 0;
    int low_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    logic [7:0] rd_buf [0:7];
    logic       nak_any;

    assign scl_line = scl_m;
    assign sda_line = sda_m & o_sda_t;

    i2c_eeprom_responder dut (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl_line),
        .i_sda      (sda_line),
        .o_sda_t    (o_sda_t),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_addr (i_cfg_addr),
        .i_cfg_data (i_cfg_data),
        .o_busy     (o_busy),
        .o_wr_done  (o_wr_done)
    );

    always #25 clk = ~clk;

    // Activity monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (o_sda_t === 1'b0) low_cnt++;
        if (o_busy === 1'b1) busy_cnt++;
        if (o_wr_done === 1'b1) done_cnt++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        b = sda_line; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
        wait_clks(1);
        i_cfg_we = 1'b0;
        wait_clks(1);
    endtask

    // Random read of n bytes from addr, ACK on all but the last byte.
    task automatic rand_read(input logic [7:0] addr, input int n);
        logic a;
        logic [7:0] d;
        nak_any = 1'b0;
        bus_start();
        write_byte(8'hA0, a); nak_any |= a;
        write_byte(addr, a);  nak_any |= a;
        bus_start();
        write_byte(8'hA1, a); nak_any |= a;
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1));
            rd_buf[i] = d;
        end
        bus_stop();
        wait_clks(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(5);
        total++; if (o_sda_t !== 1'b1) begin bad++; $display("[TB] FAIL reset_sda got=%b want=1", o_sda_t); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_wr_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_done got=%b want=0", o_wr_done); end
        reset = 1'b0;
        wait_clks(5);
        total++; if (o_sda_t !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_sda got=%b want=1", o_sda_t); end
    endtask

    task automatic test_page_read();
        int d0;
        int b0;
        for (int i = 0; i < 8; i++) cfg_write(8'(i), 8'(i + 1));
        d0 = done_cnt;
        b0 = busy_cnt;
        rand_read(8'h00, 8);
        total++; if (nak_any !== 1'b0) begin bad++; $display("[TB] FAIL page_read_ack got=%b want=0", nak_any); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rd_buf[i] !== 8'(i + 1)) begin
                bad++; $display("[TB] FAIL page_read_b%0d got=%h want=%h", i, rd_buf[i], 8'(i + 1));
            end
        end
        total++; if (busy_cnt == b0) begin bad++; $display("[TB] FAIL page_read_busy_seen got=0 want=nonzero"); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL page_read_busy_end got=%b want=0", o_busy); end
        total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL page_read_no_wr_done got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_page_write();
        int d0;
        logic a;
        logic n;
        d0 = done_cnt;
        n = 1'b0;
        bus_start();
        write_byte(8'hA0, a); n |= a;
        write_byte(8'h06, a); n |= a;
        write_byte(8'hAA, a); n |= a;
        write_byte(8'hBB, a); n |= a;
        write_byte(8'hCC, a); n |= a;
        bus_stop();
        wait_clks(4);
        total++; if (n !== 1'b0) begin bad++; $display("[TB] FAIL page_write_ack got=%b want=0", n); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("[TB] FAIL wr_done_cycles got=%0d want=1", done_cnt - d0); end
        rand_read(8'h00, 2);
        total++; if (rd_buf[0] !== 8'hCC) begin bad++; $display("[TB] FAIL wrap_mem00 got=%h want=cc", rd_buf[0]); end
        total++; if (rd_buf[1] !== 8'h02) begin bad++; $display("[TB] FAIL keep_mem01 got=%h want=02", rd_buf[1]); end
        rand_read(8'h06, 2);
        total++; if (rd_buf[0] !== 8'hAA) begin bad++; $display("[TB] FAIL mem06 got=%h want=aa", rd_buf[0]); end
        total++; if (rd_buf[1] !== 8'hBB) begin bad++; $display("[TB] FAIL mem07 got=%h want=bb", rd_buf[1]); end
    endtask

    task automatic test_abort_partial();
        int d0;
        logic a;
        cfg_write(8'h30, 8'h3C);
        d0 = done_cnt;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h30, a);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        wait_clks(4);
        total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL abort_wr_done got=%0d want=0", done_cnt - d0); end
        rand_read(8'h30, 1);
        total++; if (rd_buf[0] !== 8'h3C) begin bad++; $display("[TB] FAIL abort_mem30 got=%h want=3c", rd_buf[0]); end
    endtask

    task automatic test_wrong_addr();
        int l0;
        int b0;
        logic a;
        l0 = low_cnt;
        b0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, a);
        total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL wrong_addr_nack got=%b want=1", a); end
        write_byte(8'h00, a);
        write_byte(8'h55, a);
        bus_stop();
        wait_clks(4);
        total++; if (low_cnt != l0) begin bad++; $display("[TB] FAIL wrong_addr_sda_driven got=%0d want=0", low_cnt - l0); end
        total++; if (busy_cnt != b0) begin bad++; $display("[TB] FAIL wrong_addr_busy got=%0d want=0", busy_cnt - b0); end
        rand_read(8'h00, 1);
        total++; if (rd_buf[0] !== 8'hCC) begin bad++; $display("[TB] FAIL wrong_addr_mem00 got=%h want=cc", rd_buf[0]); end
    endtask

    task automatic test_read_wrap();
        logic a;
        logic n;
        logic [7:0] b0;
        logic [7:0] b1;
        int l0;
        cfg_write(8'hFF, 8'h5A);
        n = 1'b0;
        bus_start();
        write_byte(8'hA0, a); n |= a;
        write_byte(8'hFF, a); n |= a;
        bus_start();
        write_byte(8'hA1, a); n |= a;
        read_byte(b0, 1'b0);
        read_byte(b1, 1'b1);
        l0 = low_cnt;
        wait_clks(6 * Q);
        total++; if (low_cnt != l0) begin bad++; $display("[TB] FAIL nack_release got=%0d want=0", low_cnt - l0); end
        bus_stop();
        wait_clks(4);
        total++; if (n !== 1'b0) begin bad++; $display("[TB] FAIL wrap_read_ack got=%b want=0", n); end
        total++; if (b0 !== 8'h5A) begin bad++; $display("[TB] FAIL wrap_memff got=%h want=5a", b0); end
        total++; if (b1 !== 8'hCC) begin bad++; $display("[TB] FAIL wrap_mem00_rd got=%h want=cc", b1); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        cfg_write(8'h10, 8'h00);
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        bus_start();
        write_byte(8'hA1, a);
        total++; if (o_sda_t !== 1'b0) begin bad++; $display("[TB] FAIL rd_bit7_driven got=%b want=0", o_sda_t); end
        reset = 1'b1;
        #1;
        total++; if (o_sda_t !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_sda got=%b want=1", o_sda_t); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_busy got=%b want=0", o_busy); end
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);
        bus_stop();
        bus_start();
        write_byte(8'hA0, a);
        total++; if (a !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_ack got=%b want=0", a); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_busy got=%b want=1", o_busy); end
        bus_stop();
        wait_clks(4);
    endtask

    task automatic test_preload_busy();
        logic a;
        cfg_write(8'h20, 8'h11);
        bus_start();
        write_byte(8'hA0, a);
        total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL preload_busy got=%b want=1", o_busy); end
        cfg_write(8'h20, 8'h77);
        bus_stop();
        wait_clks(4);
        rand_read(8'h20, 1);
        total++; if (rd_buf[0] !== 8'h11) begin bad++; $display("[TB] FAIL preload_ignored got=%h want=11", rd_buf[0]); end
        cfg_write(8'h20, 8'h77);
        rand_read(8'h20, 1);
        total++; if (rd_buf[0] !== 8'h77) begin bad++; $display("[TB] FAIL preload_applied got=%h want=77", rd_buf[0]); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_page_read();
        test_page_write();
        test_abort_partial();
        test_wrong_addr();
        test_read_wrap();
        test_reset_mid_read();
        test_preload_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
